// File: rtl/counter_even_pkg.sv
// Shared types and constants for the even down-counter.
package counter_even_pkg;

  // Controller states: waiting for a load, counting, finished at zero.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default count width is COUNT_LEN+1 bits.
  localparam int COUNT_LEN_DEFAULT = 10;

  // Amount removed from the count on every enabled cycle.
  localparam int STEP = 2;

endpackage

// File: rtl/counter_even_down.sv
// Even down-counter: a load is accepted in IDLE/DONE, rounded down to
// even, then decremented by 2 per enabled cycle until it reaches zero.
// Optional macro COUNTER_EVEN_DOWN_RELOAD_EN: on the final step the count
// is reloaded from the last accepted load value and the run continues.
module counter_even_down
  import counter_even_pkg::*;
#(
  parameter int COUNT_LEN = COUNT_LEN_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               load_valid,
  input  logic [COUNT_LEN:0] load_value,
  output logic               load_ready,
  input  logic               abort,
  output logic [COUNT_LEN:0] count,
  output logic               busy,
  output logic               done,
  output logic               odd_err
);

  localparam int            CW     = COUNT_LEN + 1;
  localparam logic [CW-1:0] STEP_W = CW'(STEP);

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic          r_busy;
  logic          w_busy_next;
  logic          r_done;
  logic          w_done_next;
  logic          r_odd_err;
  logic          w_odd_err_next;
  logic          r_load_ready;
  logic          w_load_ready_next;

  logic          w_accept;
  logic          w_step;
  logic          w_final;
  logic [CW-1:0] w_load_even;
  logic          w_reload_zero;
  logic [CW-1:0] w_after_final;

  // A load is only taken outside RUN; odd values lose their LSB.
  assign w_accept    = load_valid && (r_state != RUN);
  assign w_load_even = {load_value[COUNT_LEN:1], 1'b0};

  // Abort beats enable; the >= guard keeps the count from wrapping.
  assign w_step  = (r_state == RUN) && !abort && enable && (r_count >= STEP_W);
  assign w_final = w_step && (r_count == STEP_W);

`ifdef COUNTER_EVEN_DOWN_RELOAD_EN
  logic [CW-1:0] r_reload;

  // Remember the accepted start value so the run can restart from it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_reload <= '0;
    end else if (w_accept) begin
      r_reload <= w_load_even;
    end
  end

  assign w_reload_zero = (r_reload == '0);
  assign w_after_final = r_reload;
`else
  assign w_reload_zero = 1'b1;
  assign w_after_final = '0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (w_accept) begin
          w_state_next = (w_load_even != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (abort) begin
          w_state_next = IDLE;
        end else if (w_final) begin
          w_state_next = w_reload_zero ? DONE : RUN;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    w_count_next = r_count;
    if (w_accept) begin
      w_count_next = w_load_even;
    end else if (w_final) begin
      w_count_next = w_after_final;
    end else if (w_step) begin
      w_count_next = r_count - STEP_W;
    end
    w_busy_next       = (w_state_next == RUN);
    w_load_ready_next = (w_state_next != RUN);
    w_done_next       = (w_accept && (w_load_even == '0)) || w_final;
    w_odd_err_next    = w_accept && load_value[0];
  end

  // Output registers; load_ready resets high because IDLE accepts loads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count      <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_odd_err    <= 1'b0;
      r_load_ready <= 1'b1;
    end else begin
      r_count      <= w_count_next;
      r_busy       <= w_busy_next;
      r_done       <= w_done_next;
      r_odd_err    <= w_odd_err_next;
      r_load_ready <= w_load_ready_next;
    end
  end

  assign count      = r_count;
  assign busy       = r_busy;
  assign done       = r_done;
  assign odd_err    = r_odd_err;
  assign load_ready = r_load_ready;

endmodule

// File: tb/tb_counter_even_down.sv
// Self-checking bench for counter_even_down (COUNT_LEN=10).
// Expected outputs are queued when a cycle's stimulus is driven and
// popped and compared one clock later.
module tb_counter_even_down;
  import counter_even_pkg::*;

  localparam int CL = 10;

  typedef struct packed {
    logic          en;
    logic          lv;
    logic [CL:0]   val;
    logic          ab;
  } stim_t;

  typedef struct packed {
    logic [CL:0] cnt;
    logic        busy;
    logic        done;
    logic        odd;
    logic        rdy;
  } obs_t;

  logic          clk;
  logic          reset;
  logic          enable;
  logic          load_valid;
  logic [CL:0]   load_value;
  logic          load_ready;
  logic          abort;
  logic [CL:0]   count;
  logic          busy;
  logic          done;
  logic          odd_err;

  int   checks;
  int   failures;
  obs_t exp_q[$];

  counter_even_down #(.COUNT_LEN(CL)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load_valid (load_valid),
    .load_value (load_value),
    .load_ready (load_ready),
    .abort      (abort),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .odd_err    (odd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t S(input int en, input int lv, input int val, input int ab);
    stim_t s;
    s.en  = 1'(en);
    s.lv  = 1'(lv);
    s.val = (CL+1)'(val);
    s.ab  = 1'(ab);
    return s;
  endfunction

  function automatic obs_t O(input int cnt, input int b, input int d, input int o, input int r);
    obs_t e;
    e.cnt  = (CL+1)'(cnt);
    e.busy = 1'(b);
    e.done = 1'(d);
    e.odd  = 1'(o);
    e.rdy  = 1'(r);
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t x;
    x.cnt  = count;
    x.busy = busy;
    x.done = done;
    x.odd  = odd_err;
    x.rdy  = load_ready;
    return x;
  endfunction

  // Drive one cycle of inputs and return 1 time unit after the edge.
  task automatic drive_cycle(input stim_t s);
    enable     = s.en;
    load_valid = s.lv;
    load_value = s.val;
    abort      = s.ab;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t got;
    obs_t exp;
    reset = 1'b1; enable = 1'b0; load_valid = 1'b0; load_value = '0; abort = 1'b0;
    #3;
    exp_q.push_back(O(0, 0, 0, 0, 1));
    exp = exp_q.pop_front();
    got = sample();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL reset: got count=%0d b/d/o/r=%b required count=%0d b/d/o/r=%b",
               got.cnt, got[3:0], exp.cnt, exp[3:0]);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    $display("reset: count=%0d load_ready=%b", got.cnt, got.rdy);
  endtask

  task automatic test_even_run();
    stim_t st[5];
    obs_t  ex[5];
    obs_t  got;
    obs_t  exp;
    st = '{S(1,1,6,0), S(1,0,0,0), S(1,0,0,0), S(1,0,0,0), S(1,0,0,0)};
    ex = '{O(6,1,0,0,0), O(4,1,0,0,0), O(2,1,0,0,0), O(0,0,1,0,1), O(0,0,0,0,1)};
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(ex[i]);
      drive_cycle(st[i]);
      exp = exp_q.pop_front();
      got = sample();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL even_run[%0d]: got count=%0d b/d/o/r=%b required count=%0d b/d/o/r=%b",
                 i, got.cnt, got[3:0], exp.cnt, exp[3:0]);
      end
      $display("even_run[%0d]: count=%0d busy=%b done=%b", i, got.cnt, got.busy, got.done);
    end
  endtask

  task automatic test_odd_load();
    stim_t st[5];
    obs_t  ex[5];
    obs_t  got;
    obs_t  exp;
    st = '{S(0,1,7,0), S(1,0,0,0), S(0,0,0,0), S(1,0,0,0), S(1,0,0,0)};
    ex = '{O(6,1,0,1,0), O(4,1,0,0,0), O(4,1,0,0,0), O(2,1,0,0,0), O(0,0,1,0,1)};
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(ex[i]);
      drive_cycle(st[i]);
      exp = exp_q.pop_front();
      got = sample();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL odd_load[%0d]: got count=%0d b/d/o/r=%b required count=%0d b/d/o/r=%b",
                 i, got.cnt, got[3:0], exp.cnt, exp[3:0]);
      end
      $display("odd_load[%0d]: count=%0d odd_err=%b", i, got.cnt, got.odd);
    end
  endtask

  task automatic test_zero_load();
    stim_t st[8];
    obs_t  ex[8];
    obs_t  got;
    obs_t  exp;
    // zero load, idle, load 1 (rounds to 0, flags odd), then load 8 and
    // offer new values during RUN, abort, and abort again while IDLE.
    st = '{S(0,1,0,0), S(0,0,0,0), S(0,1,1,0), S(0,1,8,0),
           S(0,1,20,0), S(1,1,20,0), S(0,0,0,1), S(0,0,0,1)};
    ex = '{O(0,0,1,0,1), O(0,0,0,0,1), O(0,0,1,1,1), O(8,1,0,0,0),
           O(8,1,0,0,0), O(6,1,0,0,0), O(6,0,0,0,1), O(6,0,0,0,1)};
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(ex[i]);
      drive_cycle(st[i]);
      exp = exp_q.pop_front();
      got = sample();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL zero_load[%0d]: got count=%0d b/d/o/r=%b required count=%0d b/d/o/r=%b",
                 i, got.cnt, got[3:0], exp.cnt, exp[3:0]);
      end
      $display("zero_load[%0d]: count=%0d done=%b load_ready=%b", i, got.cnt, got.done, got.rdy);
    end
  endtask

  task automatic test_abort();
    stim_t st[10];
    obs_t  ex[10];
    obs_t  got;
    obs_t  exp;
    // abort after two steps; abort colliding with the final step;
    // abort in DONE; then a load that the mid-run reset will cut short.
    st = '{S(0,1,10,0), S(1,0,0,0), S(1,0,0,0), S(1,0,0,1), S(1,0,0,0),
           S(0,1,4,0), S(1,0,0,0), S(1,0,0,1), S(0,1,0,0), S(0,0,0,1)};
    ex = '{O(10,1,0,0,0), O(8,1,0,0,0), O(6,1,0,0,0), O(6,0,0,0,1), O(6,0,0,0,1),
           O(4,1,0,0,0), O(2,1,0,0,0), O(2,0,0,0,1), O(0,0,1,0,1), O(0,0,0,0,1)};
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(ex[i]);
      drive_cycle(st[i]);
      exp = exp_q.pop_front();
      got = sample();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL abort[%0d]: got count=%0d b/d/o/r=%b required count=%0d b/d/o/r=%b",
                 i, got.cnt, got[3:0], exp.cnt, exp[3:0]);
      end
      $display("abort[%0d]: count=%0d busy=%b done=%b", i, got.cnt, got.busy, got.done);
    end
  endtask

  task automatic test_async_reset();
    stim_t st[3];
    obs_t  ex[3];
    obs_t  got;
    obs_t  exp;
    st = '{S(0,1,6,0), S(1,0,0,0), S(1,0,0,0)};
    ex = '{O(6,1,0,0,0), O(4,1,0,0,0), O(0,0,0,0,1)};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(ex[i]);
      if (i < 2) begin
        drive_cycle(st[i]);
      end else begin
        // mid-cycle, no clock edge: outputs must clear immediately
        enable = st[i].en;
        #2;
        reset = 1'b1;
        #1;
      end
      exp = exp_q.pop_front();
      got = sample();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL async_reset[%0d]: got count=%0d b/d/o/r=%b required count=%0d b/d/o/r=%b",
                 i, got.cnt, got[3:0], exp.cnt, exp[3:0]);
      end
      $display("async_reset[%0d]: count=%0d load_ready=%b", i, got.cnt, got.rdy);
    end
    @(posedge clk);
    #1;
    reset  = 1'b0;
    enable = 1'b0;
  endtask

`ifdef COUNTER_EVEN_DOWN_RELOAD_EN
  task automatic test_reload();
    stim_t st[7];
    obs_t  ex[7];
    obs_t  got;
    obs_t  exp;
    st = '{S(1,1,4,0), S(1,0,0,0), S(1,0,0,0), S(1,0,0,0), S(1,0,0,0), S(1,0,0,0), S(0,0,0,1)};
    ex = '{O(4,1,0,0,0), O(2,1,0,0,0), O(4,1,1,0,0), O(2,1,0,0,0), O(4,1,1,0,0),
           O(2,1,0,0,0), O(2,0,0,0,1)};
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(ex[i]);
      drive_cycle(st[i]);
      exp = exp_q.pop_front();
      got = sample();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL reload[%0d]: got count=%0d b/d/o/r=%b required count=%0d b/d/o/r=%b",
                 i, got.cnt, got[3:0], exp.cnt, exp[3:0]);
      end
      $display("reload[%0d]: count=%0d done=%b", i, got.cnt, got.done);
    end
  endtask
`else
  task automatic test_max_load();
    obs_t got;
    obs_t exp;
    int   k;
    // 2046 takes 2046/2 = 1023 enabled cycles to reach zero
    for (k = 0; k <= 1023; k++) begin
      exp_q.push_back(O(2046 - 2*k, (k < 1023) ? 1 : 0, (k == 1023) ? 1 : 0, 0,
                        (k == 1023) ? 1 : 0));
      drive_cycle((k == 0) ? S(1,1,2046,0) : S(1,0,0,0));
      exp = exp_q.pop_front();
      got = sample();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL max_load[%0d]: got count=%0d b/d/o/r=%b required count=%0d b/d/o/r=%b",
                 k, got.cnt, got[3:0], exp.cnt, exp[3:0]);
      end
      if (k == 0 || k >= 1022) begin
        $display("max_load[%0d]: count=%0d done=%b", k, got.cnt, got.done);
      end
    end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_even_run();
    test_odd_load();
    test_zero_load();
    test_abort();
    test_async_reset();
`ifdef COUNTER_EVEN_DOWN_RELOAD_EN
    test_reload();
`else
    test_max_load();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_even_down.md
COUNTER_EVEN_DOWN -- requirements
Module: counter_even_down

Interface
REQ-001 The block SHALL have parameter COUNT_LEN, default 10, giving a count width of COUNT_LEN+1 bits.
REQ-002 The block SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1 bit, asynchronous, active-high reset.
REQ-004 The block SHALL have port enable, input, 1 bit, step qualifier; the count moves only when enable=1.
REQ-005 The block SHALL have port load_valid, input, 1 bit, start-value offer.
REQ-006 The block SHALL have port load_value, input, COUNT_LEN+1 bits, start value.
REQ-007 The block SHALL have port load_ready, output, 1 bit, load accepted this cycle if load_valid=1.
REQ-008 The block SHALL have port abort, input, 1 bit, cancel the current run.
REQ-009 The block SHALL have port count, output, COUNT_LEN+1 bits, current value.
REQ-010 The block SHALL have port busy, output, 1 bit, high in RUN.
REQ-011 The block SHALL have port done, output, 1 bit, one-cycle pulse when the count reaches zero.
REQ-012 The block SHALL have port odd_err, output, 1 bit, one-cycle pulse when an odd load value was accepted.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE. Each output SHALL be registered, and count, busy, done and odd_err SHALL be driven from flops.
REQ-014 load_ready SHALL be 1 in IDLE and DONE and 0 in RUN; load_valid in RUN SHALL be ignored.
REQ-015 A load is accepted on load_valid&load_ready. On acceptance:
- count <= {load_value[COUNT_LEN:1],1'b0}, i.e. an odd value is rounded down to even.
- the reload register <= the same value.
- odd_err pulses next cycle iff load_value[0]=1.
REQ-016 An accepted nonzero load SHALL move the FSM to RUN. An accepted zero load SHALL move it to DONE, with done pulsing in the cycle DONE is entered.
REQ-017 In RUN with enable=1, count SHALL decrement by exactly 2 per clock.
REQ-018 In RUN with enable=0, count SHALL hold.
REQ-019 In RUN, when enable=1 and count=2:
- count becomes 0.
- done is 1 in the following cycle (a single pulse).
- the FSM enters DONE, unless REQ-027 applies.
REQ-020 count SHALL never underflow; arithmetic is unsigned modulo 2^(COUNT_LEN+1), and the decrement is applied only when count>=2.
REQ-021 In DONE, count SHALL stay 0 and busy SHALL be 0 until a new load is accepted.
REQ-022 abort=1 in RUN SHALL return the FSM to IDLE next cycle with count held and no done pulse. abort SHALL have priority over enable. abort in IDLE or DONE SHALL have no effect.
REQ-023 If abort and the final decrement fall in the same cycle, abort SHALL win: no done pulse, and count holds at 2.
REQ-024 Maximum load 2^(COUNT_LEN+1)-2 SHALL take (2^(COUNT_LEN+1)-2)/2 enabled cycles to reach 0.

Reset
REQ-025 reset=1 SHALL immediately set the following, independent of clk and including mid-run:
- FSM to IDLE.
- count, reload register, busy, done and odd_err to 0.
- load_ready to 1.

Configuration
REQ-026 Macro COUNTER_EVEN_DOWN_RELOAD_EN selects the auto-reload feature.
REQ-027 With COUNTER_EVEN_DOWN_RELOAD_EN defined, the final decrement (count=2, enable=1, no abort):
- pulses done.
- loads count with the reload register.
- stays in RUN.
- if the reload register is 0, enters DONE instead.
REQ-028 Without the macro, the block SHALL behave per REQ-019/021, and the reload register SHALL not be synthesised.

Structure
REQ-029 Package counter_even_pkg SHALL hold the state typedef (IDLE/RUN/DONE), the COUNT_LEN default and the step constant 2.
REQ-030 The block SHALL be a single module; no sub-module is natural.

Verification (COUNT_LEN=10)
REQ-031 Scenario: load 6, enable held 1.
- count 6 -> 4 -> 2 -> 0.
- done is a single pulse at the 0 cycle.
- busy is 1 for 3 cycles.
- FSM ends in DONE, load_ready=1.
REQ-032 Scenario: load 7.
- count=6 and odd_err is one pulse.
- then toggle enable 1,0,1: count 4, 4, 2.
REQ-033 Scenario: load 0 -> DONE and a done pulse with no RUN cycle; load_valid held in RUN -> load_ready=0, count unaffected.
REQ-034 Scenario: load 10, after 2 steps assert abort together with enable -> IDLE, count=6, no done pulse; assert reset mid-run at count=4 -> all outputs 0 asynchronously, load_ready=1.
REQ-035 Scenario: with COUNTER_EVEN_DOWN_RELOAD_EN defined, load 4, enable=1 -> 4, 2, 0->reload 4 (done pulse), 2, ... continuous; load 2046 without the macro -> done after 1023 enabled cycles.
